// File: rtl/param_bus_datapath.sv
// Single-bus datapath: GPRs, HI/LO, Z, PC, IR, MAR, Y, MDR with a memory-read sequencer.
// Optional R0_ZERO_EN: GPR0 is hardwired to zero on the bus and never loads.
module param_bus_datapath #(
    parameter int DATA_W      = 32,
    parameter int NUM_GPR     = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic [NUM_GPR+6:0]    drv_sel,
    input  logic [NUM_GPR+6:0]    ld_en,
    input  logic [DATA_W-1:0]     in_port,
    input  logic                  z_ld,
    input  logic [2*DATA_W-1:0]   z_in,
    input  logic                  mem_rd,
    input  logic                  mem_ack,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  mem_req,
    output logic [DATA_W-1:0]     mem_addr,
    output logic                  rd_done,
    output logic                  rd_err,
    output logic [DATA_W-1:0]     bus,
    output logic                  bus_conflict,
    output logic [DATA_W-1:0]     ir_out,
    output logic [DATA_W-1:0]     pc_out,
    output logic [DATA_W-1:0]     y_out
);
    localparam int N  = NUM_GPR;
    localparam int V  = NUM_GPR + 7;
    localparam int CW = $clog2(MEM_TIMEOUT + 1);
`ifdef R0_ZERO_EN
    localparam int G0 = 1;
`else
    localparam int G0 = 0;
`endif

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    logic [DATA_W-1:0] gpr [N];
    logic [DATA_W-1:0] hi, lo, zhi, zlo, pc, ir, mar, y, mdr;
    logic [DATA_W-1:0] src [V];
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_nxt;
    state_t            state;

    always_comb begin
        for (int i = 0; i < N; i++) src[i] = gpr[i];
`ifdef R0_ZERO_EN
        src[0] = '0;
`endif
        src[N]   = hi;
        src[N+1] = lo;
        src[N+2] = zhi;
        src[N+3] = zlo;
        src[N+4] = pc;
        src[N+5] = mdr;
        src[N+6] = in_port;
    end

    // Walk downward so the lowest set index is the last assignment.
    always_comb begin
        bus = '0;
        for (int i = V - 1; i >= 0; i--)
            if (drv_sel[i]) bus = src[i];
    end

    assign bus_conflict = |(drv_sel & (drv_sel - V'(1)));
    assign mem_addr     = mar;
    assign ir_out       = ir;
    assign pc_out       = pc;
    assign y_out        = y;
    assign cnt_nxt      = cnt + CW'(1);

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < N; i++) gpr[i] <= '0;
            hi  <= '0;
            lo  <= '0;
            zhi <= '0;
            zlo <= '0;
            pc  <= '0;
            ir  <= '0;
            mar <= '0;
            y   <= '0;
        end else begin
            for (int i = G0; i < N; i++)
                if (ld_en[i]) gpr[i] <= bus;
            if (ld_en[N])   hi  <= bus;
            if (ld_en[N+1]) lo  <= bus;
            if (ld_en[N+2]) pc  <= bus;
            if (ld_en[N+3]) ir  <= bus;
            if (ld_en[N+4]) mar <= bus;
            if (ld_en[N+5]) y   <= bus;
            if (z_ld) begin
                zhi <= z_in[2*DATA_W-1:DATA_W];
                zlo <= z_in[DATA_W-1:0];
            end
        end
    end

    // MDR lives here so a captured ack can take priority over a bus load.
    always_ff @(posedge clk) begin
        if (clr) begin
            state   <= S_IDLE;
            cnt     <= '0;
            mem_req <= 1'b0;
            rd_done <= 1'b0;
            rd_err  <= 1'b0;
            mdr     <= '0;
        end else begin
            rd_done <= 1'b0;
            rd_err  <= 1'b0;
            if (state == S_WAIT && mem_ack)
                mdr <= mem_rdata;
            else if (ld_en[N+6])
                mdr <= bus;
            unique case (state)
                S_IDLE: begin
                    if (mem_rd) begin
                        state   <= S_WAIT;
                        mem_req <= 1'b1;
                        cnt     <= '0;
                    end
                end
                S_WAIT: begin
                    if (mem_ack) begin
                        state   <= S_IDLE;
                        mem_req <= 1'b0;
                        rd_done <= 1'b1;
                        cnt     <= '0;
                    end else if (cnt_nxt == CW'(MEM_TIMEOUT)) begin
                        state   <= S_IDLE;
                        mem_req <= 1'b0;
                        rd_err  <= 1'b1;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt_nxt;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_param_bus_datapath.sv
// Scoreboard bench for param_bus_datapath: bus probes and memory-read
// completions are queued by stimulus and checked by a negedge monitor.
module tb_param_bus_datapath;
    localparam int W = 32;
    localparam int N = 16;
    localparam int V = N + 7;

    logic            clk = 1'b0;
    logic            clr;
    logic [V-1:0]    drv_sel, ld_en;
    logic [W-1:0]    in_port;
    logic            z_ld;
    logic [2*W-1:0]  z_in;
    logic            mem_rd, mem_ack;
    logic [W-1:0]    mem_rdata;
    logic            mem_req, rd_done, rd_err, bus_conflict;
    logic [W-1:0]    mem_addr, bus, ir_out, pc_out, y_out;

    param_bus_datapath #(.DATA_W(W), .NUM_GPR(N), .MEM_TIMEOUT(4)) dut (
        .clk(clk), .clr(clr), .drv_sel(drv_sel), .ld_en(ld_en),
        .in_port(in_port), .z_ld(z_ld), .z_in(z_in),
        .mem_rd(mem_rd), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .mem_req(mem_req), .mem_addr(mem_addr), .rd_done(rd_done),
        .rd_err(rd_err), .bus(bus), .bus_conflict(bus_conflict),
        .ir_out(ir_out), .pc_out(pc_out), .y_out(y_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] bus;
        logic         conf;
        logic         req;
        logic         regs;
        logic [W-1:0] ir;
        logic [W-1:0] pc;
        logic [W-1:0] y;
        logic [W-1:0] addr;
    } pexp_t;

    typedef struct packed {
        logic         err;
        logic [31:0]  req;
    } mexp_t;

    pexp_t pq [$];
    mexp_t mq [$];
    logic  probe_en = 1'b0;
    int    checks = 0;
    int    errors = 0;
    int    req_run = 0;

    function automatic logic [V-1:0] b(input int i);
        return V'(1) << i;
    endfunction

    task automatic chk(input string nm, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic probe(input logic [W-1:0] v, input logic c,
                         input logic r);
        pexp_t e;
        e = '0;
        e.bus = v;
        e.conf = c;
        e.req = r;
        pq.push_back(e);
        probe_en = 1'b1;
    endtask

    task automatic probe_regs(input logic [W-1:0] v, input logic r,
                              input logic [W-1:0] ir, input logic [W-1:0] pc,
                              input logic [W-1:0] y, input logic [W-1:0] a);
        pexp_t e;
        e.bus = v;
        e.conf = 1'b0;
        e.req = r;
        e.regs = 1'b1;
        e.ir = ir;
        e.pc = pc;
        e.y = y;
        e.addr = a;
        pq.push_back(e);
        probe_en = 1'b1;
    endtask

    task automatic expect_rd(input logic err, input int reqs);
        mexp_t m;
        m.err = err;
        m.req = 32'(reqs);
        mq.push_back(m);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        probe_en = 1'b0;
        clr = 1'b0;
        drv_sel = '0;
        ld_en = '0;
        mem_rd = 1'b0;
        mem_ack = 1'b0;
        z_ld = 1'b0;
    endtask

    always @(negedge clk) begin
        pexp_t e;
        mexp_t m;
        if (clr === 1'b1) req_run = 0;
        else if (mem_req === 1'b1) req_run++;
        if (probe_en) begin
            if (pq.size() == 0) begin
                chk("probe_queue", 32'(pq.size()), 32'd1);
            end else begin
                e = pq.pop_front();
                chk("bus", bus, e.bus);
                chk("bus_conflict", W'(bus_conflict), W'(e.conf));
                chk("mem_req", W'(mem_req), W'(e.req));
                if (e.regs) begin
                    chk("ir_out", ir_out, e.ir);
                    chk("pc_out", pc_out, e.pc);
                    chk("y_out", y_out, e.y);
                    chk("mem_addr", mem_addr, e.addr);
                end
            end
        end
        if (rd_done === 1'b1 || rd_err === 1'b1) begin
            if (mq.size() == 0) begin
                chk("unexpected_pulse", {30'd0, rd_done, rd_err}, 32'd0);
            end else begin
                m = mq.pop_front();
                chk("rd_err", W'(rd_err), W'(m.err));
                chk("rd_done", W'(rd_done), W'(!m.err));
                chk("req_cycles", 32'(req_run), m.req);
            end
            req_run = 0;
        end
    end

    initial begin
        clr = 1'b1;
        drv_sel = '0;
        ld_en = '0;
        in_port = '0;
        z_ld = 1'b0;
        z_in = '0;
        mem_rd = 1'b0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        tick();

        // Random prior state, a read in flight, then clr.
        in_port = $urandom() | 32'd1;
        drv_sel = b(22);
        ld_en = '1;
        z_ld = 1'b1;
        z_in = {$urandom(), $urandom()} | 64'd1;
        tick();
        mem_rd = 1'b1;
        tick();
        tick();
        clr = 1'b1;
        ld_en = '1;
        drv_sel = b(22);
        mem_rd = 1'b1;
        tick();
        drv_sel = b(1);
        probe_regs(32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        tick();
        drv_sel = b(18);
        probe(32'h0, 1'b0, 1'b0);
        tick();
        drv_sel = b(21);
        probe(32'h0, 1'b0, 1'b0);
        tick();

        // Register loads through the bus.
        in_port = 32'hDEADBEEF;
        drv_sel = b(22);
        ld_en = b(3);
        probe(32'hDEADBEEF, 1'b0, 1'b0);
        tick();
        drv_sel = b(3);
        probe(32'hDEADBEEF, 1'b0, 1'b0);
        tick();
        in_port = 32'h5A5A5A5A;
        drv_sel = b(22);
        ld_en = b(3) | b(5);
        tick();
        drv_sel = b(3);
        probe(32'h5A5A5A5A, 1'b0, 1'b0);
        tick();
        drv_sel = b(5);
        ld_en = b(18);
        probe(32'h5A5A5A5A, 1'b0, 1'b0);
        tick();
        drv_sel = b(20);
        probe(32'h5A5A5A5A, 1'b0, 1'b0);
        tick();
        in_port = 32'hCAFE0001;
        drv_sel = b(22);
        ld_en = b(16) | b(17) | b(19) | b(21);
        tick();
        drv_sel = b(16);
        ld_en = b(16) | b(17);
        probe(32'hCAFE0001, 1'b0, 1'b0);
        tick();
        drv_sel = b(5);
        ld_en = b(16);
        tick();
        drv_sel = b(16);
        probe(32'h5A5A5A5A, 1'b0, 1'b0);
        tick();
        drv_sel = b(17);
        probe(32'hCAFE0001, 1'b0, 1'b0);
        tick();

        // Priority and conflict.
        in_port = 32'h00000022;
        drv_sel = b(22);
        ld_en = b(2);
        tick();
        in_port = 32'h00001000;
        drv_sel = b(22);
        ld_en = b(18);
        tick();
        drv_sel = b(2) | b(20);
        probe(32'h00000022, 1'b1, 1'b0);
        tick();
        drv_sel = '0;
        probe(32'h0, 1'b0, 1'b0);
        tick();
        in_port = 32'h0000FFFF;
        drv_sel = b(22) | b(17) | b(3);
        probe(32'h5A5A5A5A, 1'b1, 1'b0);
        tick();
        drv_sel = b(22);
        probe(32'h0000FFFF, 1'b0, 1'b0);
        tick();

        // Z register halves.
        z_ld = 1'b1;
        z_in = 64'h11112222_33334444;
        tick();
        drv_sel = b(18);
        probe(32'h11112222, 1'b0, 1'b0);
        tick();
        drv_sel = b(19);
        probe(32'h33334444, 1'b0, 1'b0);
        tick();

        // Memory read, ack in the third WAIT cycle.
        in_port = 32'h00000040;
        drv_sel = b(22);
        ld_en = b(20);
        tick();
        mem_rd = 1'b1;
        probe(32'h0, 1'b0, 1'b0);
        expect_rd(1'b0, 3);
        tick();
        probe_regs(32'h0, 1'b1, 32'hCAFE0001, 32'h00001000,
                   32'hCAFE0001, 32'h00000040);
        tick();
        tick();
        mem_ack = 1'b1;
        mem_rdata = 32'h00001234;
        tick();
        drv_sel = b(21);
        probe(32'h00001234, 1'b0, 1'b0);
        tick();

        // Ack in the first WAIT cycle beats a same-edge bus load of MDR.
        mem_rd = 1'b1;
        expect_rd(1'b0, 1);
        tick();
        mem_ack = 1'b1;
        mem_rdata = 32'h00005678;
        in_port = 32'h00000BAD;
        drv_sel = b(22);
        ld_en = b(22);
        probe(32'h00000BAD, 1'b0, 1'b1);
        tick();
        drv_sel = b(21);
        probe(32'h00005678, 1'b0, 1'b0);
        tick();

        // Timeout after four WAIT cycles; extra mem_rd and idle ack ignored.
        mem_rd = 1'b1;
        expect_rd(1'b1, 4);
        tick();
        tick();
        mem_rd = 1'b1;
        tick();
        tick();
        probe(32'h0, 1'b0, 1'b1);
        tick();
        mem_ack = 1'b1;
        mem_rdata = 32'h00009999;
        drv_sel = b(21);
        probe(32'h00005678, 1'b0, 1'b0);
        tick();
        drv_sel = b(21);
        probe(32'h00005678, 1'b0, 1'b0);
        tick();

        // clr in the middle of WAIT.
        mem_rd = 1'b1;
        tick();
        probe(32'h0, 1'b0, 1'b1);
        tick();
        clr = 1'b1;
        tick();
        drv_sel = b(21);
        probe(32'h0, 1'b0, 1'b0);
        tick();
        repeat (5) tick();

        // GPR0 behaviour.
        in_port = 32'h00000005;
        drv_sel = b(22);
        ld_en = b(0);
        tick();
        drv_sel = b(0);
`ifdef R0_ZERO_EN
        probe(32'h0, 1'b0, 1'b0);
`else
        probe(32'h00000005, 1'b0, 1'b0);
`endif
        tick();
        repeat (2) tick();

        chk("mem_queue_left", 32'(mq.size()), 32'd0);
        chk("probe_queue_left", 32'(pq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
